// File: rtl/bitwise_issuer.sv
// bitwise_issuer
//   Command initiator for the bitwise register-write controller. Commands
//   (op, data) are queued in a small circular FIFO. On go the queue drains one
//   command at a time: a single-cycle strobe s presents the FIFO head on
//   op/cmd_data, then the issuer waits for done before issuing the next. A
//   watchdog moves to a sticky error state if done never arrives.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   push/push_op/push_data   enqueue a command (dropped when full)
//   go                start draining (idle) / clear error (error state)
//   done              responder complete, sampled only while waiting
//   s/op/cmd_data     command strobe and payload to the controller
//   full/empty/count  FIFO status
//   busy              issuing or waiting for done
//   error             watchdog expired; held until go
module bitwise_issuer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [3:0]               push_op,
    input  logic [7:0]               push_data,
    input  logic                     go,
    input  logic                     done,
    output logic                     s,
    output logic [3:0]               op,
    output logic [7:0]               cmd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [7:0]    TIMEOUT_M1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      wdog_q, wdog_d;

    logic [3:0]      mem_op_q   [DEPTH];
    logic [7:0]      mem_data_q [DEPTH];
    logic [3:0]      held_op_q;
    logic [7:0]      held_data_q;

    logic            push_ok;
    logic            pop;

    // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        push_ok  = push && (count_q != DEPTH_C);
        pop      = (state_q == ST_ISSUE);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state and watchdog. done wins over the watchdog on the same edge.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (go && (count_q != '0)) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    // count_q already reflects the pop made on the issue cycle.
                    state_d = (count_q != '0) ? ST_ISSUE : ST_IDLE;
                end else if (wdog_q == TIMEOUT_M1) begin
                    state_d = ST_ERR;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            ST_ERR: begin
                if (go) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wdog_q   <= wdog_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by state, and the
    // pointers/count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_op_q[wr_ptr_q]   <= push_op;
            mem_data_q[wr_ptr_q] <= push_data;
        end
        if (pop) begin
            held_op_q   <= mem_op_q[rd_ptr_q];
            held_data_q <= mem_data_q[rd_ptr_q];
        end
    end

    // Outputs decode from state only, so reset forces them low immediately.
    always_comb begin
        s        = 1'b0;
        op       = '0;
        cmd_data = '0;
        case (state_q)
            ST_ISSUE: begin
                s        = 1'b1;
                op       = mem_op_q[rd_ptr_q];
                cmd_data = mem_data_q[rd_ptr_q];
            end
            ST_WAIT: begin
                op       = held_op_q;
                cmd_data = held_data_q;
            end
            default: begin
                s        = 1'b0;
            end
        endcase
    end

    assign busy  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign error = (state_q == ST_ERR);
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: tb/tb_bitwise_issuer.sv
// Testbench for bitwise_issuer: directed stimulus; every accepted push records
// its expected (op, data) in a queue, and an independent monitor pops and
// compares whenever the DUT strobes s.
module tb_bitwise_issuer;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [3:0] push_op;
    logic [7:0] push_data;
    logic       go;
    logic       done;
    logic       s;
    logic [3:0] op;
    logic [7:0] cmd_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       busy;
    logic       error;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    logic [8:0]  s_pat;

    bitwise_issuer #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .push(push), .push_op(push_op),
        .push_data(push_data), .go(go), .done(done), .s(s), .op(op),
        .cmd_data(cmd_data), .full(full), .empty(empty), .count(count),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Inputs change at the falling edge; outputs are also read there.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_push(input logic [3:0] o, input logic [7:0] d, input bit accepted);
        push = 1'b1; push_op = o; push_data = d;
        if (accepted) exp_q.push_back({o, d});
        cyc();
        push = 1'b0;
    endtask

    // Scoreboard monitor.
    initial begin
        logic prev_s;
        logic [11:0] e;
        prev_s = 1'b0;
        forever begin
            @(negedge clk);
            if (s === 1'b1) begin
                chk("s_single_cycle", {31'd0, prev_s}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue actual op=%0h data=%0h required no strobe", op, cmd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_op", {28'd0, op}, {28'd0, e[11:8]});
                    chk("issue_data", {24'd0, cmd_data}, {24'd0, e[7:0]});
                end
            end
            prev_s = s;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; push = 1'b0; push_op = '0; push_data = '0; go = 1'b0; done = 1'b0;
        cyc(); cyc();
        chk("rst_s", s, 0); chk("rst_op", op, 0); chk("rst_data", cmd_data, 0);
        chk("rst_busy", busy, 0); chk("rst_error", error, 0);
        chk("rst_count", count, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        reset = 1'b0;
        cyc();

        // Single command.
        done = 1'b1;
        do_push(4'h1, 8'hA5, 1'b1);
        chk("t1_count", count, 1);
        go = 1'b1; cyc(); go = 1'b0;
        chk("t1_s_high", s, 1); chk("t1_busy", busy, 1);
        cyc();
        chk("t1_s_low", s, 0); chk("t1_wait_op", op, 4'h1); chk("t1_wait_data", cmd_data, 8'hA5);
        cyc();
        chk("t1_idle_busy", busy, 0); chk("t1_empty", empty, 1);

        // Fill to full, overflow dropped, back-to-back drain.
        do_push(4'h0, 8'h11, 1'b1);
        do_push(4'h1, 8'h22, 1'b1);
        do_push(4'h2, 8'h33, 1'b1);
        do_push(4'h3, 8'h44, 1'b1);
        chk("t2_full", full, 1); chk("t2_count4", count, 4);
        do_push(4'hF, 8'hFF, 1'b0);
        chk("t2_count_after_drop", count, 4);
        go = 1'b1; cyc(); go = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s_pat[i] = s;
            if (i < 8) cyc();
        end
        chk("t2_s_pattern", {23'd0, s_pat}, 32'h055);
        chk("t2_idle", busy, 0); chk("t2_empty", empty, 1);

        // Pointer wrap with pushes during draining, then watchdog.
        done = 1'b0;
        do_push(4'h5, 8'hA1, 1'b1);
        do_push(4'h6, 8'hB2, 1'b1);
        do_push(4'h7, 8'hC3, 1'b1);
        chk("t3_count3", count, 3);
        go = 1'b1; cyc(); go = 1'b0;
        chk("t3_issue_a", s, 1);
        do_push(4'h8, 8'hD4, 1'b1);        // push and pop on the same edge
        chk("t3_count_pushpop", count, 3);
        do_push(4'hE, 8'hE5, 1'b1);        // push during WAIT
        chk("t3_count4", count, 4);
        done = 1'b1; cyc(); done = 1'b0;
        chk("t3_issue_b", s, 1);
        cyc();
        chk("t3_count_after_b", count, 3);
        for (int i = 0; i < 14; i++) cyc();
        chk("t4_no_err_yet", error, 0); chk("t4_busy", busy, 1);
        cyc();
        chk("t4_error", error, 1); chk("t4_err_s", s, 0); chk("t4_err_op", op, 0);
        chk("t4_err_busy", busy, 0); chk("t4_err_count", count, 3);
        cyc();
        chk("t4_error_sticky", error, 1);
        go = 1'b1; cyc(); go = 1'b0;
        chk("t4_cleared", error, 0); chk("t4_idle", busy, 0);
        go = 1'b1; cyc(); go = 1'b0;
        chk("t4_resume_s", s, 1);
        cyc();
        chk("t5_count2", count, 2);

        // Asynchronous reset mid-WAIT.
        #2 reset = 1'b1;
        #1;
        chk("t5_s", s, 0); chk("t5_busy", busy, 0);
        chk("t5_count", count, 0); chk("t5_empty", empty, 1);
        exp_q.delete();
        cyc();
        reset = 1'b0;
        cyc();
        go = 1'b1; cyc(); go = 1'b0;
        chk("t5_go_nothing_s", s, 0); chk("t5_go_nothing_busy", busy, 0);
        cyc();
        chk("t5_still_idle", busy, 0);

        // done on the timeout edge wins over the watchdog.
        do_push(4'h9, 8'h5A, 1'b1);
        go = 1'b1; cyc(); go = 1'b0;
        cyc();                             // WAIT cycle 1
        for (int i = 0; i < 14; i++) cyc(); // now WAIT cycle 15
        done = 1'b1; cyc(); done = 1'b0;
        chk("t6_done_priority_err", error, 0); chk("t6_idle", busy, 0);

        // go while empty.
        go = 1'b1; cyc(); go = 1'b0;
        chk("t7_empty_go_s", s, 0); chk("t7_empty_go_busy", busy, 0);
        cyc(); cyc();
        chk("t7_scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitwise_issuer.md
# bitwise_issuer

Command initiator for the `bitwise` register-write controller. It buffers up to DEPTH queued (op, data) commands. On `go`, it drains them one at a time onto the controller's `s`/`op`/`in` inputs and waits for the controller's `done` before issuing the next. A watchdog flags a responder that never returns `done`.

## Interface
- DEPTH, 4, command FIFO depth (power of two, ≥2)
- TIMEOUT, 15, maximum WAIT cycles without `done` before error (1..255)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- push  input  1  enqueue {push_op, push_data} this cycle
- push_op  input  4  opcode to enqueue
- push_data  input  8  data byte to enqueue
- go  input  1  start draining (IDLE) / clear error (ERR)
- done  input  1  responder ready/complete, driven by controller
- s  output  1  command strobe to controller
- op  output  4  opcode to controller
- cmd_data  output  8  data byte to controller `in`
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  log2(DEPTH)+1  FIFO occupancy
- busy  output  1  state is ISSUE or WAIT
- error  output  1  timeout occurred; sticky

## Operation
- FIFO:
  - Circular buffer with read and write pointers that wrap mod DEPTH.
  - Push is accepted only if `full`=0 at the clock edge. A push while full is dropped with no side effect.
  - Pop happens on the ISSUE cycle.
  - Simultaneous accepted push and pop leaves count unchanged.
- FSM states: IDLE, ISSUE, WAIT, ERR.
  - IDLE: s=0, op=0, cmd_data=0. go=1 with empty=0 → ISSUE. go=1 with empty=1 → stays IDLE.
  - ISSUE (exactly 1 cycle): s=1, op/cmd_data = FIFO head. Pop head; clear watchdog → WAIT.
  - WAIT:
    - s=0; op/cmd_data hold the issued values.
    - done=1 → ISSUE if FIFO non-empty after the pop, else IDLE.
    - done=0 → watchdog++. When watchdog reaches TIMEOUT → ERR.
  - ERR: s=0, error=1, op/cmd_data=0. FIFO contents are preserved. go=1 → IDLE with error cleared.
- Pushes are accepted in every state, including during draining.
- Commands are issued in push order. Opcode values are not interpreted, so unknown ops are issued like any other.
- Reset values:
  - s=0, op=0, cmd_data=0, busy=0, error=0.
  - count=0, empty=1, full=0.
  - Pointers 0, state IDLE, watchdog 0.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously). Queued commands are discarded.

## Timing
- `go` is sampled at the edge. s=1 during the first cycle after the edge that samples go=1 in IDLE.
- `s` is a single-cycle pulse per command and is never high on two consecutive cycles.
- `done` is sampled only in WAIT. A `done` seen during ISSUE is ignored.
- Minimum cost is 2 cycles per command (ISSUE plus one WAIT with done=1).
- A back-to-back burst of N commands issues s on cycles 1, 3, 5, … after go.
- ERR is entered on the edge where watchdog reaches TIMEOUT, i.e. after TIMEOUT consecutive WAIT cycles with done=0. done=1 on that same edge takes priority: the FSM does not enter ERR.
- count, full and empty update on the edge after push/pop.

## Test plan
- Reset, push (op=0001,data=8'hA5), pulse go:
  - s=1, op=0001, cmd_data=A5 on the cycle after go, for one cycle only.
  - Hold done=1 → IDLE, empty=1, busy=0.
- Push 4 commands (ops 0000..0011, data 11,22,33,44):
  - full=1, count=4. A 5th push is dropped.
  - go with done held 1 → s pulses on cycles 1,3,5,7 in push order, then IDLE.
- Drain 2 of 3 commands, pushing during WAIT:
  - Order is preserved across the pointer wrap.
  - count is correct with simultaneous push+pop on an ISSUE cycle.
- go, then hold done=0:
  - error=1 after TIMEOUT=15 WAIT cycles, s=0, remaining FIFO count unchanged.
  - go → IDLE, error=0.
  - go again resumes with the next queued command.
- Assert reset asynchronously mid-WAIT with 2 entries queued:
  - s=0, busy=0, count=0, empty=1 immediately.
  - A subsequent go does nothing.
- go while empty → no s pulse, busy stays 0.
